// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: one request at a time, drives a combinational-read data memory.
// Optional LSU_MISALIGN_CHECK_EN rejects misaligned halfword/word accesses.
module lsu_mem_initiator #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_func3,
  input  logic [AW-1:0] req_base,
  input  logic [AW-1:0] req_offset,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_func3,
  output logic          mem_wr_en,
  output logic          mem_rd_en,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic          we_q;
  logic [2:0]    func3_q;
  logic [AW-1:0] addr_next;
  logic          illegal;
  logic          misalign;
  logic          reject;

  assign addr_next = req_base + req_offset;

  always_comb begin
    if (req_we) illegal = !(req_func3 inside {3'b000, 3'b001, 3'b010});
    else        illegal = req_func3 inside {3'b011, 3'b110, 3'b111};
  end

`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    misalign = ((req_func3[1:0] == 2'b01) && addr_next[0]) ||
               ((req_func3[1:0] == 2'b10) && (addr_next[1:0] != 2'b00));
  end
`else
  assign misalign = 1'b0;
`endif

  assign reject = illegal | misalign;

  function automatic logic [DW-1:0] extend(input logic [2:0] f3, input logic [DW-1:0] d);
    case (f3)
      3'b000:  extend = {{(DW-8){d[7]}}, d[7:0]};
      3'b001:  extend = {{(DW-16){d[15]}}, d[15:0]};
      3'b100:  extend = {{(DW-8){1'b0}}, d[7:0]};
      3'b101:  extend = {{(DW-16){1'b0}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      func3_q    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            func3_q   <= req_func3;
            mem_addr  <= addr_next;
            mem_wdata <= req_wdata;
            if (reject) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          resp_rdata <= we_q ? '0 : extend(func3_q, mem_rdata);
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are decoded from state; the write strobe is gated by rst so a
  // reset landing in ACCESS never commits a store.
  assign req_ready = (state == IDLE);
  assign mem_rd_en = (state == ACCESS) && !we_q;
  assign mem_wr_en = (state == ACCESS) && we_q && !rst;
  assign mem_func3 = {1'b0, func3_q[1:0]};

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Scoreboard bench for lsu_mem_initiator with a byte-addressed memory device and
// an independent reference memory model.
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_base, req_offset, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_func3;
  logic        mem_wr_en, mem_rd_en;

  lsu_mem_initiator #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_func3(req_func3), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_func3(mem_func3),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory device seen by the DUT (little-endian bytes, 1 KiB, wraps).
  bit [7:0] dev_mem [0:1023];
  logic [9:0] da;
  assign da = mem_addr[9:0];
  assign mem_rdata = {dev_mem[da + 10'd3], dev_mem[da + 10'd2], dev_mem[da + 10'd1], dev_mem[da]};

  always @(posedge clk) begin
    if (mem_wr_en) begin
      dev_mem[da] <= mem_wdata[7:0];
      if (mem_func3[1:0] != 2'b00) dev_mem[da + 10'd1] <= mem_wdata[15:8];
      if (mem_func3[1:0] == 2'b10) begin
        dev_mem[da + 10'd2] <= mem_wdata[23:16];
        dev_mem[da + 10'd3] <= mem_wdata[31:24];
      end
    end
  end

  // Reference model state.
  bit [7:0] ref_mem [0:1023];

  typedef struct {
    logic        err;
    logic        we;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  mf3;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;
  int hold    = 0;
  bit rand_rr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int access_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic exp_t model(input logic we, input logic [2:0] f3,
                                 input logic [31:0] base, input logic [31:0] off,
                                 input logic [31:0] wd);
    exp_t e;
    logic [31:0] w;
    logic [9:0] ix;
    bit bad;
    e.addr  = base + off;
    e.we    = we;
    e.wdata = wd;
    e.mf3   = {1'b0, f3[1:0]};
    e.acc_cyc = 0;
    if (we) bad = (f3 > 3'd2);
    else    bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
`ifdef LSU_MISALIGN_CHECK_EN
    if (!bad && (e.addr % access_size(f3)) != 0) bad = 1'b1;
`endif
    e.err = bad;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      ix = e.addr[9:0] + 10'(i);
      w[8*i +: 8] = ref_mem[ix];
    end
    if (bad || we) e.rdata = '0;
    else begin
      case (f3)
        3'd0:    e.rdata = 32'($signed(w[7:0]));
        3'd1:    e.rdata = 32'($signed(w[15:0]));
        3'd4:    e.rdata = 32'(w[7:0]);
        3'd5:    e.rdata = 32'(w[15:0]);
        default: e.rdata = w;
      endcase
    end
    return e;
  endfunction

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] off, input logic [31:0] wd, input bit commit);
    exp_t e;
    logic [9:0] ix;
    int t = 0;
    @(posedge clk); #1;
    while (!req_ready && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 32'(req_ready), 32'd1);
      return;
    end
    e = model(we, f3, base, off, wd);
    e.acc_cyc = cyc;
    sb.push_back(e);
    if (commit && we && !e.err) begin
      for (int i = 0; i < access_size(f3); i++) begin
        ix = e.addr[9:0] + 10'(i);
        ref_mem[ix] = wd[8*i +: 8];
      end
    end
    req_valid = 1'b1; req_we = we; req_func3 = f3;
    req_base = base; req_offset = off; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Response channel driver.
  initial begin
    resp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (hold > 0) begin
        resp_ready = 1'b0;
        hold--;
      end else begin
        resp_ready = rand_rr ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor: checks memory strobes and responses against the scoreboard front.
  initial begin
    int  acc_cnt = 0;
    bit  seen = 1'b0;
    exp_t f;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc_cnt = 0;
        seen = 1'b0;
      end else begin
        if (mem_rd_en || mem_wr_en) begin
          if (sb.size() == 0) chk("spurious_access", 32'd1, 32'd0);
          else begin
            f = sb[0];
            chk("access_on_error", 32'(f.err), 32'd0);
            chk("mem_rd_en", 32'(mem_rd_en), 32'(!f.we));
            chk("mem_wr_en", 32'(mem_wr_en), 32'(f.we));
            chk("mem_addr", mem_addr, f.addr);
            chk("mem_func3", 32'(mem_func3), 32'(f.mf3));
            if (f.we) chk("mem_wdata", mem_wdata, f.wdata);
            acc_cnt++;
          end
        end
        if (resp_valid) begin
          if (sb.size() == 0) chk("spurious_resp", 32'd1, 32'd0);
          else begin
            f = sb[0];
            chk("req_ready_in_resp", 32'(req_ready), 32'd0);
            if (!seen) begin
              chk("latency", 32'(cyc - f.acc_cyc), f.err ? 32'd1 : 32'd2);
              seen = 1'b1;
            end
            chk("resp_rdata", resp_rdata, f.rdata);
            chk("resp_err", 32'(resp_err), 32'(f.err));
            if (resp_ready) begin
              chk("access_count", 32'(acc_cnt), f.err ? 32'd0 : 32'd1);
              void'(sb.pop_front());
              acc_cnt = 0;
              seen = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_func3 = '0;
    req_base = '0; req_offset = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_func3", 32'(mem_func3), 32'd0);
    chk("rst_strobes", {30'd0, mem_wr_en, mem_rd_en}, 32'd0);

    issue(1'b1, 3'd2, 32'h100, 32'h4, 32'hDEADBEEF, 1'b1);
    issue(1'b0, 3'd2, 32'h100, 32'h4, 32'h0, 1'b1);
    issue(1'b1, 3'd2, 32'h40, 32'h0, 32'h00000080, 1'b1);
    issue(1'b0, 3'd0, 32'h40, 32'h0, 32'h0, 1'b1);
    issue(1'b0, 3'd4, 32'h40, 32'h0, 32'h0, 1'b1);
    issue(1'b1, 3'd2, 32'h48, 32'h0, 32'h00008001, 1'b1);
    issue(1'b0, 3'd1, 32'h48, 32'h0, 32'h0, 1'b1);
    issue(1'b0, 3'd5, 32'h48, 32'h0, 32'h0, 1'b1);
    issue(1'b1, 3'd1, 32'h20, 32'hFFFFFFFC, 32'h1234ABCD, 1'b1);
    issue(1'b0, 3'd2, 32'h1C, 32'h0, 32'h0, 1'b1);
    issue(1'b0, 3'd3, 32'h100, 32'h4, 32'h0, 1'b1);
    issue(1'b1, 3'd4, 32'h100, 32'h4, 32'h55, 1'b1);
    issue(1'b0, 3'd7, 32'h100, 32'h0, 32'h0, 1'b1);
    drain();
    hold = 6;
    issue(1'b0, 3'd2, 32'h100, 32'h4, 32'h0, 1'b1);
    issue(1'b0, 3'd2, 32'hFFFFFFFC, 32'h8, 32'h0, 1'b1);
    issue(1'b0, 3'd2, 32'h100, 32'h2, 32'h0, 1'b1);
    issue(1'b1, 3'd1, 32'h41, 32'h0, 32'hBEEF, 1'b1);
    drain();

    // Store interrupted by reset while in ACCESS must leave memory untouched.
    issue(1'b1, 3'd2, 32'h200, 32'h0, 32'hCAFEF00D, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_access_wr_en", 32'(mem_wr_en), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
    issue(1'b0, 3'd2, 32'h200, 32'h0, 32'h0, 1'b1);
    drain();

    rand_rr = 1'b1;
    for (int n = 0; n < 200; n++) begin
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            32'($urandom_range(0, 255)), 32'($urandom_range(0, 32)) - 32'd16,
            $urandom, 1'b1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
